// File: rtl/cpc_raster_int_gen.sv
// Raster interrupt generator for the CPC gate-array: divides HSYNC falls by DIV,
// resynchronises on VSYNC and holds /INT until acknowledged, cleared or timed out.
module cpc_raster_int_gen #(
  parameter int CNT_W       = 6,
  parameter int DIV         = 52,
  parameter int VS_DELAY    = 2,
  parameter int HOLD_MAX    = 96,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             int_ack_i,
  input  logic             rmri_i,
  input  logic             int_en_i,
  output logic             nint_o,
  output logic             int_pending_o,
  output logic [CNT_W-1:0] cntr_o
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam int VSN_W  = $clog2(VS_DELAY + 1);

  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  MSB_CLR  = ~(CNT_W'(1) << (CNT_W - 1));
  localparam logic [VSN_W-1:0]  VS_LAST  = VSN_W'(VS_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  typedef enum logic {
    VS_IDLE = 1'b0,
    VS_WAIT = 1'b1
  } vs_state_t;

  logic [SYNC_STAGES-1:0] hs_sync;
  logic [SYNC_STAGES-1:0] vs_sync;
  logic                   hs_d;
  logic                   vs_d;
  logic                   ack_d;
  logic                   rmri_d;

  logic                   hs_fall;
  logic                   vs_rise;
  logic                   ack_rise;
  logic                   rmri_rise;

  vs_state_t              vs_state;
  vs_state_t              vs_state_nxt;
  logic [VSN_W-1:0]       vs_n;
  logic [VSN_W-1:0]       vs_n_nxt;
  logic                   resync;

  logic [CNT_W-1:0]       cntr;
  logic [CNT_W-1:0]       cntr_m;
  logic [CNT_W-1:0]       cntr_nxt;
  logic                   pend_set;
  logic                   pending;
  logic                   pending_nxt;
  logic [HOLD_W-1:0]      hold;
  logic [HOLD_W-1:0]      hold_nxt;

  // Synchronisers plus one history flop per input for edge detection.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      hs_sync <= '0;
      vs_sync <= '0;
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      ack_d   <= 1'b0;
      rmri_d  <= 1'b0;
    end else begin
      hs_sync[0] <= hsync_i;
      vs_sync[0] <= vsync_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        hs_sync[i] <= hs_sync[i-1];
        vs_sync[i] <= vs_sync[i-1];
      end
      hs_d   <= hs_sync[SYNC_STAGES-1];
      vs_d   <= vs_sync[SYNC_STAGES-1];
      ack_d  <= int_ack_i;
      rmri_d <= rmri_i;
    end
  end

  assign hs_fall   = hs_d & ~hs_sync[SYNC_STAGES-1];
  assign vs_rise   = ~vs_d & vs_sync[SYNC_STAGES-1];
  assign ack_rise  = int_ack_i & ~ack_d;
  assign rmri_rise = rmri_i & ~rmri_d;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      vs_state <= VS_IDLE;
      vs_n     <= '0;
      cntr     <= '0;
      pending  <= 1'b0;
      hold     <= '0;
    end else begin
      vs_state <= vs_state_nxt;
      vs_n     <= vs_n_nxt;
      cntr     <= cntr_nxt;
      pending  <= pending_nxt;
      hold     <= hold_nxt;
    end
  end

  // A vsync rise restarts the wait even in the cycle the resync point fires.
  always_comb begin
    vs_state_nxt = vs_state;
    vs_n_nxt     = vs_n;
    resync       = 1'b0;
    case (vs_state)
      VS_IDLE: begin
        if (vs_rise) begin
          vs_state_nxt = VS_WAIT;
          vs_n_nxt     = '0;
        end
      end
      VS_WAIT: begin
        if (hs_fall) begin
          if (vs_n == VS_LAST) begin
            resync       = 1'b1;
            vs_state_nxt = VS_IDLE;
          end else begin
            vs_n_nxt = vs_n + VSN_W'(1);
          end
        end
        if (vs_rise) begin
          vs_state_nxt = VS_WAIT;
          vs_n_nxt     = '0;
        end
      end
      default: vs_state_nxt = VS_IDLE;
    endcase
  end

  always_comb begin
    cntr_m   = ack_rise ? (cntr & MSB_CLR) : cntr;
    cntr_nxt = cntr_m;
    pend_set = 1'b0;
    if (rmri_rise) begin
      cntr_nxt = '0;
    end else if (resync) begin
      cntr_nxt = '0;
      pend_set = cntr[CNT_W-1];
    end else if (hs_fall) begin
      if (cntr_m == DIV_LAST) begin
        cntr_nxt = '0;
        pend_set = 1'b1;
      end else begin
        cntr_nxt = cntr_m + CNT_W'(1);
      end
    end
  end

  // A fresh interrupt outranks an ack or timeout landing in the same cycle.
  always_comb begin
    pending_nxt = pending;
    hold_nxt    = hold;
    if (rmri_rise) begin
      pending_nxt = 1'b0;
      hold_nxt    = '0;
    end else if (pend_set) begin
      pending_nxt = 1'b1;
      hold_nxt    = HOLD_W'(1);
    end else if (pending && (ack_rise || hold == HOLD_LIM)) begin
      pending_nxt = 1'b0;
      hold_nxt    = '0;
    end else if (pending) begin
      hold_nxt = hold + HOLD_W'(1);
    end
  end

  assign nint_o        = ~(pending & int_en_i);
  assign int_pending_o = pending;
  assign cntr_o        = cntr;

endmodule

// File: tb/tb_cpc_raster_int_gen.sv
// Bench for cpc_raster_int_gen: two parameterisations share one stimulus stream and
// are checked every cycle against an arithmetic reference model via expected queues.
module tb_cpc_raster_int_gen;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic hsync = 1'b0, vsync = 1'b0, int_ack = 1'b0, rmri = 1'b0, int_en = 1'b1;

  logic       nint_a, pend_a;
  logic [5:0] cntr_a;
  logic       nint_b, pend_b;
  logic [1:0] cntr_b;

  always #5 clk = ~clk;

  cpc_raster_int_gen #(.CNT_W(6), .DIV(52), .VS_DELAY(2), .HOLD_MAX(96), .SYNC_STAGES(2)) dut_a (
    .clk_i(clk), .nreset_i(nreset), .hsync_i(hsync), .vsync_i(vsync),
    .int_ack_i(int_ack), .rmri_i(rmri), .int_en_i(int_en),
    .nint_o(nint_a), .int_pending_o(pend_a), .cntr_o(cntr_a)
  );

  cpc_raster_int_gen #(.CNT_W(2), .DIV(4), .VS_DELAY(1), .HOLD_MAX(5), .SYNC_STAGES(3)) dut_b (
    .clk_i(clk), .nreset_i(nreset), .hsync_i(hsync), .vsync_i(vsync),
    .int_ack_i(int_ack), .rmri_i(rmri), .int_en_i(int_en),
    .nint_o(nint_b), .int_pending_o(pend_b), .cntr_o(cntr_b)
  );

  // Per-instance parameters as seen by the model.
  function automatic int p_cw(int i);   return (i == 0) ? 6  : 2; endfunction
  function automatic int p_div(int i);  return (i == 0) ? 52 : 4; endfunction
  function automatic int p_vsd(int i);  return (i == 0) ? 2  : 1; endfunction
  function automatic int p_hold(int i); return (i == 0) ? 96 : 5; endfunction
  function automatic int p_sync(int i); return (i == 0) ? 2  : 3; endfunction

  // Reference model state: sample history (bit 0 = latest edge) and per-instance counters.
  logic [7:0] hist_h, hist_v;
  logic       ack_prev, rmri_prev;
  int cnt [2];
  int pend [2];
  int hold [2];
  int vwait [2];
  int vn [2];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic h_s = 1'b0, v_s = 1'b0, a_s = 1'b0, r_s = 1'b0, e_s = 1'b1;

  task automatic model_reset();
    hist_h = '0;
    hist_v = '0;
    ack_prev = 1'b0;
    rmri_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; pend[i] = 0; hold[i] = 0; vwait[i] = 0; vn[i] = 0;
    end
  endtask

  task automatic model_step();
    bit hf, vr, ar, rr, rs, set;
    int half, m, s;
    ar = int_ack && !ack_prev;
    rr = rmri && !rmri_prev;
    for (int i = 0; i < 2; i++) begin
      s    = p_sync(i);
      hf   = hist_h[s] && !hist_h[s-1];
      vr   = !hist_v[s] && hist_v[s-1];
      half = 1 << (p_cw(i) - 1);
      rs   = vwait[i] != 0 && hf && (vn[i] + 1 == p_vsd(i));
      if (vr) begin
        vwait[i] = 1; vn[i] = 0;
      end else if (vwait[i] != 0 && hf) begin
        if (rs) vwait[i] = 0;
        else vn[i] = vn[i] + 1;
      end
      set = 0;
      if (rr) cnt[i] = 0;
      else if (rs) begin
        set = (cnt[i] >= half);
        cnt[i] = 0;
      end else begin
        m = ar ? (cnt[i] % half) : cnt[i];
        if (hf && m == p_div(i) - 1) begin
          cnt[i] = 0; set = 1;
        end else cnt[i] = hf ? m + 1 : m;
      end
      if (rr) begin
        pend[i] = 0; hold[i] = 0;
      end else if (set) begin
        pend[i] = 1; hold[i] = 1;
      end else if (pend[i] != 0 && (ar || hold[i] == p_hold(i))) begin
        pend[i] = 0; hold[i] = 0;
      end else if (pend[i] != 0) hold[i] = hold[i] + 1;
    end
    hist_h = {hist_h[6:0], hsync};
    hist_v = {hist_v[6:0], vsync};
    ack_prev = int_ack;
    rmri_prev = rmri;
  endtask

  function automatic logic [7:0] exp_word(int i);
    logic ni, pe;
    pe = (pend[i] != 0);
    ni = !(pe && int_en);
    return {ni, pe, 6'(cnt[i])};
  endfunction

  // One clock: advance model on the edge, then apply the next inputs and record expectations.
  task automatic cycle(input logic h, input logic v, input logic a, input logic r,
                       input logic e, input logic n);
    @(posedge clk);
    if (nreset) model_step();
    #1;
    hsync = h; vsync = v; int_ack = a; rmri = r; int_en = e; nreset = n;
    if (!n) model_reset();
    exp_q0.push_back(exp_word(0));
    exp_q1.push_back(exp_word(1));
    cyc++;
  endtask

  task automatic tick(int k);
    repeat (k) cycle(h_s, v_s, a_s, r_s, e_s, 1'b1);
  endtask

  task automatic hpulse(int k);
    repeat (k) begin
      h_s = 1'b1; tick(2);
      h_s = 1'b0; tick(4);
    end
  endtask

  task automatic pulse_ack();
    a_s = 1'b1; tick(1); a_s = 1'b0; tick(1);
  endtask

  task automatic do_reset(int k);
    repeat (k) cycle(h_s, v_s, a_s, r_s, e_s, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [7:0] e, a;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a = {nint_a, pend_a, cntr_a};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL dut_a_outputs t=%0t {nint,pending,cntr} actual=%b_%b_%0d required=%b_%b_%0d",
                 $time, a[7], a[6], a[5:0], e[7], e[6], e[5:0]);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      a = {nint_b, pend_b, 4'b0000, cntr_b};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL dut_b_outputs t=%0t {nint,pending,cntr} actual=%b_%b_%0d required=%b_%b_%0d",
                 $time, a[7], a[6], a[5:0], e[7], e[6], e[5:0]);
      end
    end
  end

  initial begin
    int h_timer;
    model_reset();
    do_reset(3);
    tick(4);

    // Full 52-line frame division, then ack with counter in the late half.
    hpulse(52);
    tick(10);
    hpulse(40);
    pulse_ack();
    tick(6);
    // Unacknowledged interrupt runs to its hold timeout.
    hpulse(44);
    tick(110);
    // VSYNC resync from late half (raises IRQ) and early half (no IRQ).
    hpulse(35 - 0);
    v_s = 1'b1; hpulse(2); v_s = 1'b0;
    tick(8);
    hpulse(20);
    v_s = 1'b1; hpulse(2); v_s = 1'b0;
    tick(8);
    // RMR clear with an IRQ pending.
    hpulse(52);
    r_s = 1'b1; tick(1); r_s = 1'b0; tick(6);
    // Masked interrupt stays pending.
    hpulse(52);
    e_s = 1'b0; tick(20);
    e_s = 1'b1; tick(10);
    // Asynchronous reset in the middle of a hold.
    hpulse(52);
    tick(30);
    do_reset(2);
    tick(10);

    // Randomised traffic.
    h_timer = 0;
    repeat (6000) begin
      if (h_timer == 0) begin
        h_s = ~h_s;
        h_timer = h_s ? $urandom_range(1, 3) : $urandom_range(2, 6);
      end else h_timer--;
      if (v_s) begin
        if ($urandom_range(0, 15) == 0) v_s = 1'b0;
      end else if ($urandom_range(0, 299) == 0) v_s = 1'b1;
      a_s = ($urandom_range(0, 39) == 0) ? 1'b1 : (a_s && ($urandom_range(0, 1) == 1));
      r_s = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0) e_s = ~e_s;
      if ($urandom_range(0, 2499) == 0) do_reset(2);
      else tick(1);
    end

    tick(4);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
